heart_rate_controller: RTL

HEART_RATE_CONTROLLER -- requirements
Module: heart_rate_controller

---
 rtl/hr_pkg.sv | 36 +++
 rtl/sample_tick_gen.sv | 38 +++
 rtl/heart_rate_controller.sv | 146 ++++++++++++++
 3 files changed

// File: rtl/hr_pkg.sv
`default_nettype none
// ============================================================================
// Package     : hr_pkg
// Description : Shared state encoding, widths and BPM scaling for the
//               heart-rate controller.
// Revision    : 1.0 - initial release
// ============================================================================
package hr_pkg;

    localparam int c_BEAT_W   = 6;
    localparam int c_BPM_W    = 8;
    localparam int c_BEAT_MAX = (1 << c_BEAT_W) - 1;
    localparam int c_BPM_MAX  = (1 << c_BPM_W) - 1;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_SETTLE  = 2'd1,
        ST_MEASURE = 2'd2,
        ST_REPORT  = 2'd3
    } hr_state_t;

    // Product is formed at 32 bits so the clamp sees the true value.
    function automatic logic [c_BPM_W-1:0] bpm_from_beats(
        input logic [c_BEAT_W-1:0] beat_cnt,
        input int                  mult
    );
        logic [31:0] prod;
        prod = 32'(beat_cnt) * 32'(mult);
        if (prod > 32'(c_BPM_MAX)) begin
            return c_BPM_W'(c_BPM_MAX);
        end
        return prod[c_BPM_W-1:0];
    endfunction

endpackage
`default_nettype wire

// File: rtl/sample_tick_gen.sv
`default_nettype none
// ============================================================================
// Module      : sample_tick_gen
// Description : Free-running sample-rate divider with registered tick pulse.
// Revision    : 1.0 - initial release
// ============================================================================
module sample_tick_gen #(
    parameter int DIV = 50000
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    output logic tick
);

    localparam int c_CNT_W = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [c_CNT_W-1:0] c_LAST = c_CNT_W'(DIV - 1);

    logic [c_CNT_W-1:0] r_cnt;
    logic               r_tick;

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            r_cnt  <= '0;
            r_tick <= 1'b0;
        end else if (r_cnt == c_LAST) begin
            r_cnt  <= '0;
            r_tick <= 1'b1;
        end else begin
            r_cnt  <= r_cnt + 1'b1;
            r_tick <= 1'b0;
        end
    end

    assign tick = r_tick;

endmodule
`default_nettype wire

// File: rtl/heart_rate_controller.sv
`default_nettype none
// ============================================================================
// Module      : heart_rate_controller
// Description : Counts refractory-filtered peaks over a sample window and
//               reports beats and BPM through a valid/ready handshake.
// Revision    : 1.0 - initial release
// ============================================================================
module heart_rate_controller
    import hr_pkg::*;
#(
    parameter int SAMPLE_DIV         = 50000,
    parameter int SETTLE_SAMPLES     = 31,
    parameter int WINDOW_SAMPLES     = 15000,
    parameter int REFRACTORY_SAMPLES = 300,
    parameter int BPM_MULT           = 4
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                start,
    input  logic                stop,
    input  logic                continuous,
    input  logic                peak,
    input  logic                result_ready,
    output logic                sample_en,
    output logic                busy,
    output logic                result_valid,
    output logic [c_BPM_W-1:0]  bpm,
    output logic [c_BEAT_W-1:0] beats
);

    localparam int c_SAMP_MAX = (SETTLE_SAMPLES > WINDOW_SAMPLES) ? SETTLE_SAMPLES : WINDOW_SAMPLES;
    localparam int c_SAMP_W   = (c_SAMP_MAX > 0) ? $clog2(c_SAMP_MAX + 1) : 1;
    localparam int c_REFR_W   = (REFRACTORY_SAMPLES > 0) ? $clog2(REFRACTORY_SAMPLES + 1) : 1;

    hr_state_t             r_state;
    hr_state_t             w_state_next;
    logic                  w_tick;
    logic                  w_clear;
    logic [c_SAMP_W-1:0]   r_samp_cnt;
    logic [c_BEAT_W-1:0]   r_beat_cnt;
    logic [c_REFR_W-1:0]   r_refr;
    logic [c_BPM_W-1:0]    r_bpm;
    logic [c_BEAT_W-1:0]   r_beats;
    logic                  r_valid;
    logic                  r_busy;
    logic                  w_settle_done;
    logic                  w_window_done;
    logic                  w_accept;
    logic [c_BEAT_W-1:0]   w_beat_next;

    // Divider is held in REPORT too, so no sample_en fires while a result waits
    // and a continuous restart sees a full first sample period.
    assign w_clear = (r_state == ST_IDLE) || (r_state == ST_REPORT);

    sample_tick_gen #(
        .DIV (SAMPLE_DIV)
    ) u_tick (
        .clk   (clk),
        .reset (reset),
        .clear (w_clear),
        .tick  (w_tick)
    );

    assign w_settle_done = (SETTLE_SAMPLES == 0) ||
                           (w_tick && (r_samp_cnt == c_SAMP_W'(SETTLE_SAMPLES - 1)));
    assign w_window_done = w_tick && (r_samp_cnt == c_SAMP_W'(WINDOW_SAMPLES - 1));
    assign w_accept      = (r_state == ST_MEASURE) && peak && !stop && (r_refr == '0);
    assign w_beat_next   = !w_accept ? r_beat_cnt :
                           (r_beat_cnt == c_BEAT_W'(c_BEAT_MAX)) ? r_beat_cnt :
                           r_beat_cnt + 1'b1;

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE:    if (start && !stop) w_state_next = ST_SETTLE;
            ST_SETTLE:  if (stop) w_state_next = ST_IDLE;
                        else if (w_settle_done) w_state_next = ST_MEASURE;
            ST_MEASURE: if (stop) w_state_next = ST_IDLE;
                        else if (w_window_done) w_state_next = ST_REPORT;
            ST_REPORT:  if (stop) w_state_next = ST_IDLE;
                        else if (result_ready) w_state_next = continuous ? ST_MEASURE : ST_IDLE;
            default:    w_state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_IDLE;
            r_busy  <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_busy  <= (w_state_next != ST_IDLE);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_samp_cnt <= '0;
            r_beat_cnt <= '0;
            r_refr     <= '0;
            r_bpm      <= '0;
            r_beats    <= '0;
            r_valid    <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    r_samp_cnt <= '0;
                    r_beat_cnt <= '0;
                    r_refr     <= '0;
                end
                ST_SETTLE: begin
                    if (w_settle_done)  r_samp_cnt <= '0;
                    else if (w_tick)    r_samp_cnt <= r_samp_cnt + 1'b1;
                end
                ST_MEASURE: begin
                    if (w_tick) r_samp_cnt <= r_samp_cnt + 1'b1;
                    r_beat_cnt <= w_beat_next;
                    if (w_accept)                    r_refr <= c_REFR_W'(REFRACTORY_SAMPLES);
                    else if (w_tick && r_refr != '0) r_refr <= r_refr - 1'b1;
                    if (w_state_next == ST_REPORT) begin
                        r_beats <= w_beat_next;
                        r_bpm   <= bpm_from_beats(w_beat_next, BPM_MULT);
                        r_valid <= 1'b1;
                    end
                end
                ST_REPORT: begin
                    if (w_state_next != ST_REPORT) begin
                        r_valid    <= 1'b0;
                        r_samp_cnt <= '0;
                        r_beat_cnt <= '0;
                        r_refr     <= '0;
                    end
                end
                default: ;
            endcase
        end
    end

    assign sample_en    = w_tick;
    assign busy         = r_busy;
    assign result_valid = r_valid;
    assign bpm          = r_bpm;
    assign beats        = r_beats;

endmodule
`default_nettype wire
